buffer_drain: RTL and testbench

- Downstream consumer of the N-bit `buffer` stage.
- Generates that stage's read strobe (its `out_en`) and captures the `out` word a fixed number of cycles later.
- Queues captured words in a small FIFO and presents them on a valid/ready stream to the next stage.
- Credit counting ensures a read is never issued unless FIFO space is reserved, so backpressure never drops a word.

---
 rtl/buffer_drain.sv | 98 +++++++++
 tb/tb_buffer_drain.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/buffer_drain.sv
// Read-side drain for the `buffer` stage: issues read strobes against reserved
// FIFO credits, captures the returned words, and streams them out valid/ready.
module buffer_drain #(
  parameter int N      = 32,
  parameter int DEPTH  = 4,
  parameter int RD_LAT = 1,
  parameter int CW     = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_enable,
  output logic                   o_buf_rd,
  input  logic [N-1:0]           i_buf_out,
  output logic [N-1:0]           o_m_data,
  output logic                   o_m_valid,
  input  logic                   i_m_ready,
  output logic [$clog2(DEPTH):0] o_level,
  output logic [CW-1:0]          o_rd_count,
  output logic                   o_busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int SW = LW + 3;

  logic          r_buf_rd;
  logic          r_m_valid;
  logic          r_busy;
  logic [N-1:0]  r_m_data;
  logic [LW-1:0] r_level;
  logic [CW-1:0] r_rd_count;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [RD_LAT-1:0] r_vld_pipe;
  logic [N-1:0]  r_mem [DEPTH];

  logic              w_push;
  logic              w_pop;
  logic [LW-1:0]     w_level_next;
  logic [AW-1:0]     w_wr_ptr_next;
  logic [AW-1:0]     w_rd_ptr_next;
  logic [RD_LAT-1:0] w_vld_pipe_next;
  logic [SW-1:0]     w_inflight_next;
  logic              w_rd_next;

  always_comb begin
    w_push          = r_vld_pipe[RD_LAT-1];
    w_pop           = r_m_valid & i_m_ready;
    w_level_next    = r_level + LW'(w_push) - LW'(w_pop);
    w_wr_ptr_next   = r_wr_ptr + AW'(w_push);
    w_rd_ptr_next   = r_rd_ptr + AW'(w_pop);
    w_vld_pipe_next = RD_LAT'({r_vld_pipe, r_buf_rd});
    w_inflight_next = '0;
    for (int i = 0; i < RD_LAT; i++)
      w_inflight_next = w_inflight_next + SW'(w_vld_pipe_next[i]);
    // Credit check on post-edge occupancy so a new strobe always has a slot.
    w_rd_next = i_enable && ((SW'(w_level_next) + w_inflight_next) < SW'(DEPTH));
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_buf_rd   <= 1'b0;
      r_vld_pipe <= '0;
      r_busy     <= 1'b0;
      r_level    <= '0;
      r_m_valid  <= 1'b0;
      r_m_data   <= '0;
      r_rd_count <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      r_buf_rd   <= w_rd_next;
      r_vld_pipe <= w_vld_pipe_next;
      r_busy     <= |w_vld_pipe_next;
      r_level    <= w_level_next;
      r_m_valid  <= (w_level_next != '0);
      r_wr_ptr   <= w_wr_ptr_next;
      r_rd_ptr   <= w_rd_ptr_next;
      if (w_push)
        r_rd_count <= r_rd_count + CW'(1);
      // Head register; bypass when the new head is the word written this edge.
      if (w_level_next != '0)
        r_m_data <= (w_push && (w_rd_ptr_next == r_wr_ptr)) ? i_buf_out
                                                            : r_mem[w_rd_ptr_next];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst && w_push)
      r_mem[r_wr_ptr] <= i_buf_out;
  end

  assign o_buf_rd   = r_buf_rd;
  assign o_m_data   = r_m_data;
  assign o_m_valid  = r_m_valid;
  assign o_level    = r_level;
  assign o_rd_count = r_rd_count;
  assign o_busy     = r_busy;
endmodule

// File: tb/tb_buffer_drain.sv
// Directed bench for buffer_drain: three instances (RD_LAT 1/3/2) share stimulus,
// each scenario checks only the instance it targets.
module tb_buffer_drain;
  logic        clk = 1'b0;
  logic        rst, enable, m_ready;
  logic [31:0] buf_out;

  logic        a_rd, a_valid, a_busy;
  logic [31:0] a_data;
  logic [2:0]  a_level;
  logic [3:0]  a_cnt;

  logic        b_rd, b_valid, b_busy;
  logic [31:0] b_data;
  logic [2:0]  b_level;
  logic [15:0] b_cnt;

  logic        c_rd, c_valid, c_busy;
  logic [31:0] c_data;
  logic [2:0]  c_level;
  logic [15:0] c_cnt;

  int n_run = 0, n_fail = 0, ovf = 0;
  int npulse, nbusy;

  always #5 clk = ~clk;

  buffer_drain #(.N(32), .DEPTH(4), .RD_LAT(1), .CW(4)) u_a (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .o_buf_rd(a_rd),
    .i_buf_out(buf_out), .o_m_data(a_data), .o_m_valid(a_valid),
    .i_m_ready(m_ready), .o_level(a_level), .o_rd_count(a_cnt), .o_busy(a_busy));

  buffer_drain #(.N(32), .DEPTH(4), .RD_LAT(3), .CW(16)) u_b (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .o_buf_rd(b_rd),
    .i_buf_out(buf_out), .o_m_data(b_data), .o_m_valid(b_valid),
    .i_m_ready(m_ready), .o_level(b_level), .o_rd_count(b_cnt), .o_busy(b_busy));

  buffer_drain #(.N(32), .DEPTH(4), .RD_LAT(2), .CW(16)) u_c (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .o_buf_rd(c_rd),
    .i_buf_out(buf_out), .o_m_data(c_data), .o_m_valid(c_valid),
    .i_m_ready(m_ready), .o_level(c_level), .o_rd_count(c_cnt), .o_busy(c_busy));

  // Occupancy above DEPTH would mean a push landed on a full FIFO.
  always @(negedge clk)
    if (a_level > 3'd4 || b_level > 3'd4 || c_level > 3'd4) ovf++;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; enable = 1'b1; m_ready = 1'b1; buf_out = '0;

    // reset hold with enable high
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rst_rd",  a_rd,    0);
      chk("rst_vld", a_valid, 0);
      chk("rst_lvl", a_level, 0);
      chk("rst_cnt", a_cnt,   0);
    end

    // streaming on RD_LAT=1, buf_out = edge index; continues to counter wrap
    rst = 1'b1;
    for (int j = 1; j <= 19; j++) begin
      step();
      buf_out = j;
      chk("str_rd", a_rd, 1);
      chk("str_lvl_le1", a_level <= 3'd1, 1);
      if (j >= 3) chk("str_data", a_data, j - 1);
      if (j == 10) chk("str_cnt8", a_cnt, 8);
    end
    chk("wrap_cnt",  a_cnt,  1);
    chk("wrap_data", a_data, 18);

    // backpressure: credits stop reads at 4 words
    rst = 1'b0; step();
    rst = 1'b1; enable = 1'b1; m_ready = 1'b0; buf_out = 100;
    npulse = 0;
    for (int j = 1; j <= 10; j++) begin
      step();
      buf_out = 100 + j;
      npulse += int'(a_rd);
    end
    chk("bp_pulses",  npulse,  4);
    chk("bp_lvl",     a_level, 4);
    chk("bp_rd_held", a_rd,    0);
    chk("bp_head",    a_data,  102);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    chk("bp_lvl3",  a_level, 3);
    chk("bp_head2", a_data,  103);
    npulse = int'(a_rd);
    for (int j = 0; j < 5; j++) begin
      step();
      npulse += int'(a_rd);
    end
    chk("bp_one_more", npulse,  1);
    chk("bp_refill",   a_level, 4);

    // latency on RD_LAT=3: one strobe, data valid three cycles later
    rst = 1'b0; enable = 1'b0; m_ready = 1'b0; buf_out = '0;
    step();
    rst = 1'b1; enable = 1'b1;
    step();
    enable = 1'b0;
    chk("lat_rd", b_rd, 1);
    nbusy = 0;
    for (int k = 2; k <= 8; k++) begin
      step();
      buf_out = (k == 4) ? 32'hA5A5_A5A5 : 32'h0;
      nbusy += int'(b_busy);
      if (k == 2) chk("lat_single_rd", b_rd, 0);
      if (k == 4) chk("lat_pre_vld", b_valid, 0);
      if (k == 5) begin
        chk("lat_vld",  b_valid, 1);
        chk("lat_data", b_data,  32'hA5A5_A5A5);
        chk("lat_cnt",  b_cnt,   1);
        chk("lat_lvl",  b_level, 1);
      end
    end
    chk("lat_busy3", nbusy, 3);

    // reset mid-flight on RD_LAT=2 with two reads outstanding
    rst = 1'b0; enable = 1'b0;
    step();
    rst = 1'b1; enable = 1'b1; m_ready = 1'b0; buf_out = 32'hDEAD_0000;
    step(); step(); step();
    chk("mf_busy_pre", c_busy,  1);
    chk("mf_lvl_pre",  c_level, 0);
    rst = 1'b0;
    step();
    chk("mf_lvl",  c_level, 0);
    chk("mf_cnt",  c_cnt,   0);
    chk("mf_busy", c_busy,  0);
    chk("mf_vld",  c_valid, 0);
    chk("mf_rd",   c_rd,    0);
    rst = 1'b1; enable = 1'b0;
    for (int j = 0; j < 4; j++) begin
      step();
      chk("mf_vld_after", c_valid, 0);
    end
    chk("mf_data_after", c_data, 0);
    chk("mf_cnt_after",  c_cnt,  0);

    chk("no_overflow", ovf, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
